// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multicycle MIPS-subset core.
//   mc_state_e : FSM state encoding (also visible on the state_o debug port)
//   OP_* / FN_*: opcode and R-type funct field values
//   alu_ctl_e  : ALU operation select
//   mc_ctl_t   : per-cycle datapath strobes driven by mc_ctrl
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BEQ    = 4'd8,
    S_EXEC_I = 4'd9,
    S_WB_I   = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } mc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctl_e;

  typedef struct packed {
    logic     ir_we;      // fetch completes: IR <= rdata, PC <= PC+4
    logic     dec_we;     // latch A/B and the branch target
    logic     alu_we;     // ALUOut <= ALU result
    logic     alu_imm;    // ALU second operand is sext(imm) instead of B
    logic     mdr_we;     // load data completes
    logic     rf_we;
    logic     rf_dst_rd;  // destination rd (R-type) instead of rt
    logic     rf_src_mdr; // write-back data from load register
    logic     pc_branch;  // PC <= ALUOut (taken beq)
    logic     pc_jump;
    logic     addr_alu;   // memory address from ALUOut instead of PC
    alu_ctl_e alu_ctl;
  } mc_ctl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  endfunction

  function automatic alu_ctl_e funct_to_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  funct_to_alu = ALU_SUB;
      FN_AND:  funct_to_alu = ALU_AND;
      FN_OR:   funct_to_alu = ALU_OR;
      FN_SLT:  funct_to_alu = ALU_SLT;
      default: funct_to_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle FSM and instruction decode.
// Ports:
//   clk, rst_ni       clock, asynchronous active-low reset
//   opcode_i/funct_i  fields of the latched instruction register
//   mem_ready_i       memory completes the current transfer
//   a_eq_b_i          beq comparison of the latched operands
//   mem_req_o/we_o    memory request / write strobe
//   ctl_o             datapath strobes for the current cycle
//   err_o             sticky illegal-instruction flag
//   state_o           current state encoding
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  input  logic       a_eq_b_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output mc_ctl_t    ctl_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  mc_state_e state_q;
  mc_state_e dec_next;
  logic      err_q;

  always_comb begin
    dec_next = S_ERROR;
    case (opcode_i)
      OP_RTYPE:     dec_next = funct_ok(funct_i) ? S_EXEC_R : S_ERROR;
      OP_LW, OP_SW: dec_next = S_MEMADR;
      OP_BEQ:       dec_next = S_BEQ;
      OP_ADDI:      dec_next = S_EXEC_I;
      OP_J:         dec_next = S_JUMP;
      default:      dec_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready_i) state_q <= S_DECODE;
        S_DECODE: begin
          state_q <= dec_next;
          if (dec_next == S_ERROR) err_q <= 1'b1;
        end
        S_EXEC_R: state_q <= S_WB_R;
        S_EXEC_I: state_q <= S_WB_I;
        S_MEMADR: state_q <= (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready_i) state_q <= S_MEMWB;
        S_MEMWR:  if (mem_ready_i) state_q <= S_FETCH;
        S_WB_R, S_WB_I, S_MEMWB, S_BEQ, S_JUMP: state_q <= S_FETCH;
        S_ERROR:  state_q <= S_ERROR;
        default: begin
          state_q <= S_ERROR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  // Request is a decode of the state register, gated by reset so it drops
  // the moment reset asserts and is already up in the first cycle after.
  assign mem_req_o = rst_ni && (state_q == S_FETCH || state_q == S_MEMRD ||
                                state_q == S_MEMWR);
  assign mem_we_o  = rst_ni && (state_q == S_MEMWR);
  assign err_o     = err_q;
  assign state_o   = state_q;

  always_comb begin
    ctl_o         = '0;
    ctl_o.alu_ctl = ALU_ADD;
    case (state_q)
      S_FETCH:  ctl_o.ir_we  = mem_ready_i;
      S_DECODE: ctl_o.dec_we = 1'b1;
      S_EXEC_R: begin
        ctl_o.alu_we  = 1'b1;
        ctl_o.alu_ctl = funct_to_alu(funct_i);
      end
      S_WB_R: begin
        ctl_o.rf_we     = 1'b1;
        ctl_o.rf_dst_rd = 1'b1;
      end
      S_MEMADR, S_EXEC_I: begin
        ctl_o.alu_we  = 1'b1;
        ctl_o.alu_imm = 1'b1;
      end
      S_MEMRD: begin
        ctl_o.addr_alu = 1'b1;
        ctl_o.mdr_we   = mem_ready_i;
      end
      S_MEMWB: begin
        ctl_o.rf_we      = 1'b1;
        ctl_o.rf_src_mdr = 1'b1;
      end
      S_MEMWR:  ctl_o.addr_alu  = 1'b1;
      S_BEQ:    ctl_o.pc_branch = a_eq_b_i;
      S_WB_I:   ctl_o.rf_we     = 1'b1;
      S_JUMP:   ctl_o.pc_jump   = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath -- multicycle MIPS-subset core over one unified memory.
// Holds PC, IR, A, B, ALUOut, load-data register, the 32-entry register
// file and the ALU; sequencing comes from mc_ctrl.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   mem_req/mem_we        transfer request, 1 = write
//   mem_addr/mem_wdata    byte address / store data
//   mem_rdata/mem_ready   read data / transfer completes this cycle
//   err                   sticky illegal-instruction flag
//   state_o               FSM state encoding for debug
module mc_datapath
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            err,
  output logic [3:0]      state_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q, b_q, alu_q, mdr_q;
  logic [XLEN-1:0] rf_q [1:31];
  logic [XLEN-1:0] rf_rd [32];

  mc_ctl_t         ctl;
  logic [4:0]      rs, rt, rd, rf_waddr;
  logic [XLEN-1:0] imm_sext, alu_b, alu_res, rf_wdata;

  mc_ctrl u_ctrl (
    .clk        (clk),
    .rst_ni     (reset),
    .opcode_i   (ir_q[31:26]),
    .funct_i    (ir_q[5:0]),
    .mem_ready_i(mem_ready),
    .a_eq_b_i   (a_q == b_q),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .ctl_o      (ctl),
    .err_o      (err),
    .state_o    (state_o)
  );

  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sext = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

  // Read port view with register 0 hard-wired to zero.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf_rd
      if (gi == 0) begin : g_zero
        assign rf_rd[gi] = '0;
      end else begin : g_reg
        assign rf_rd[gi] = rf_q[gi];
      end
    end
  endgenerate

  always_comb begin
    alu_b   = ctl.alu_imm ? imm_sext : b_q;
    alu_res = a_q + alu_b;
    case (ctl.alu_ctl)
      ALU_ADD: alu_res = a_q + alu_b;
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(alu_b)};
      default: alu_res = a_q + alu_b;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (ctl.ir_we)     pc_d = pc_q + PC_STEP;
    if (ctl.pc_branch) pc_d = alu_q;
    if (ctl.pc_jump)   pc_d = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
  end

  assign mem_addr  = ctl.addr_alu ? alu_q : pc_q;
  assign mem_wdata = b_q;
  assign rf_waddr  = ctl.rf_dst_rd ? rd : rt;
  assign rf_wdata  = ctl.rf_src_mdr ? mdr_q : alu_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (ctl.ir_we) ir_q <= mem_rdata[31:0];
      if (ctl.dec_we) begin
        a_q   <= rf_rd[rs];
        b_q   <= rf_rd[rt];
        // PC already points past this instruction, so this is the beq target.
        alu_q <= pc_q + (imm_sext << 2);
      end
      if (ctl.alu_we) alu_q <= alu_res;
      if (ctl.mdr_we) mdr_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) rf_q[i] <= '0;
    end else if (ctl.rf_we && rf_waddr != 5'd0) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  state_o;

  logic        mem_req64, mem_we64, err64;
  logic [63:0] mem_addr64, mem_wdata64, mem_rdata64;
  logic [3:0]  state64;

  logic [31:0] prog  [256];
  logic [31:0] mem   [256];
  logic [63:0] mem64 [256];

  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        unstable = 1'b0;
  logic        in_wait = 1'b0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  logic [31:0] last_w_addr = '0, last_w_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc;

  assign mem_ready   = (wcnt >= wait_cfg);
  assign mem_rdata   = mem[mem_addr[9:2]];
  assign mem_rdata64 = mem64[mem_addr64[9:2]];

  mc_datapath #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .err(err), .state_o(state_o)
  );

  mc_datapath #(.XLEN(64), .RESET_PC(64'h0)) dut64 (
    .clk(clk), .reset(reset), .mem_req(mem_req64), .mem_we(mem_we64),
    .mem_addr(mem_addr64), .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata64),
    .mem_ready(1'b1), .err(err64), .state_o(state64)
  );

  // Memory model: program image copied in during reset, wait states per
  // transfer, stores committed on completion, hold-stability monitor.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
      wcnt    <= 0;
      in_wait <= 1'b0;
    end else begin
      if (mem_req && in_wait &&
          (mem_addr !== h_addr || mem_we !== h_we || (mem_we && mem_wdata !== h_wdata)))
        unstable <= 1'b1;
      in_wait <= mem_req && !mem_ready;
      h_addr  <= mem_addr;
      h_we    <= mem_we;
      h_wdata <= mem_wdata;
      if (mem_req && mem_ready) begin
        wcnt <= 0;
        if (mem_we) begin
          mem[mem_addr[9:2]] <= mem_wdata;
          last_w_addr        <= mem_addr;
          last_w_data        <= mem_wdata;
        end
      end else if (mem_req) begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Cycles until the next cycle that starts a fetch from addr.
  task automatic wait_fetch(input logic [31:0] addr, input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(state_o == 4'd0 && mem_req && !mem_we && mem_addr == addr) && n < 300);
    check({tag, "_reached"}, 64'(n < 300), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem64[i] = 64'h0;
    mem64[0]  = 64'h8C01_0040;            // lw   $1,0x40($0)
    mem64[1]  = 64'h2002_0001;            // addi $2,$0,1
    mem64[2]  = 64'h0022_1820;            // add  $3,$1,$2
    mem64[3]  = 64'h0800_0003;            // j    self
    mem64[16] = 64'h0000_0000_FFFF_FFFF;

    // ---- addi / addi / add, zero wait ----
    clear_prog();
    prog[0] = 32'h2001_0005;              // addi $1,$0,5
    prog[1] = 32'h2002_FFFD;              // addi $2,$0,-3
    prog[2] = 32'h0022_1820;              // add  $3,$1,$2
    prog[3] = 32'hAC01_0008;              // sw   $1,8($0)
    prog[4] = 32'h8C04_0008;              // lw   $4,8($0)
    prog[5] = 32'h0800_0005;              // j    self
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_err",     64'(err),     64'd0);
    check("rst_state",   64'(state_o), 64'd0);
    check("rst_pc",      64'(dut.pc_q), 64'h0);
    check("rst_ir",      64'(dut.ir_q), 64'h0);
    reset = 1'b1;
    #1;
    check("rel_mem_req",  64'(mem_req),  64'd1);
    check("rel_mem_addr", 64'(mem_addr), 64'h0);
    tick(11);
    check("add_rf3_early", 64'(dut.rf_q[3]), 64'h0);
    tick(1);
    check("add_rf3", 64'(dut.rf_q[3]), 64'h2);
    check("add_rf2", 64'(dut.rf_q[2]), 64'hFFFF_FFFD);
    check("add_pc",  64'(dut.pc_q),    64'hC);

    // ---- sw / lw with three wait cycles per transfer ----
    wait_cfg = 3;
    #1;
    check("wait_ready_low", 64'(mem_ready), 64'd0);
    wait_fetch(32'h10, "sw_wait", cyc);
    check("sw_wait_cycles", 64'(cyc),         64'd10);
    check("sw_addr",        64'(last_w_addr), 64'h8);
    check("sw_data",        64'(last_w_data), 64'h5);
    wait_fetch(32'h14, "lw_wait", cyc);
    check("lw_wait_cycles", 64'(cyc),            64'd11);
    check("lw_rf4",         64'(dut.rf_q[4]),    64'h5);
    check("hold_stable",    64'(unstable),       64'd0);
    wait_cfg = 0;

    // ---- beq taken at 0x10 ----
    clear_prog();
    prog[0] = 32'h2001_0005;              // addi $1,$0,5
    prog[1] = 32'h2002_FFFD;              // addi $2,$0,-3
    prog[2] = 32'h2005_0001;              // addi $5,$0,1
    prog[3] = 32'h2006_0002;              // addi $6,$0,2
    prog[4] = 32'h1021_0002;              // beq  $1,$1,+2
    prog[5] = 32'hFC00_0000;
    prog[6] = 32'hFC00_0000;
    prog[7] = 32'h0800_0007;              // j    self
    do_reset();
    wait_fetch(32'h10, "beq_t_pre", cyc);
    check("beq_t_pre_cycles", 64'(cyc), 64'd16);
    wait_fetch(32'h1C, "beq_t", cyc);
    check("beq_taken_cycles", 64'(cyc), 64'd3);

    // ---- beq not taken at 0x10 ----
    prog[4] = 32'h1022_0002;              // beq  $1,$2,+2
    do_reset();
    wait_fetch(32'h10, "beq_n_pre", cyc);
    wait_fetch(32'h14, "beq_n", cyc);
    check("beq_not_taken_cycles", 64'(cyc), 64'd3);

    // ---- j 0x40 ----
    clear_prog();
    prog[0]  = 32'h0800_0040;             // j 0x40 -> 0x100
    prog[64] = 32'h0800_0040;             // j 0x40 at 0x100
    do_reset();
    wait_fetch(32'h100, "j_first", cyc);
    check("j_first_cycles", 64'(cyc), 64'd3);
    wait_fetch(32'h100, "j_self", cyc);
    check("j_self_cycles", 64'(cyc), 64'd3);

    // ---- illegal opcode 0x3F ----
    clear_prog();
    prog[0] = 32'hFC00_0000;
    do_reset();
    tick(1);
    check("ill_decode_state", 64'(state_o), 64'd1);
    check("ill_err_early",    64'(err),     64'd0);
    tick(1);
    check("ill_err",   64'(err),     64'd1);
    check("ill_state", 64'(state_o), 64'd12);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("ill_mem_req_low", 64'(mem_req), 64'd0);
    end
    check("ill_err_sticky", 64'(err),      64'd1);
    check("ill_pc_frozen",  64'(dut.pc_q), 64'h4);

    // ---- illegal R-type funct ----
    prog[0] = 32'h0022_1821;              // funct 0x21
    do_reset();
    tick(2);
    check("bad_funct_err",   64'(err),     64'd1);
    check("bad_funct_state", 64'(state_o), 64'd12);

    // ---- ALU ops, r0 handling, zero-wait sw/lw timing ----
    clear_prog();
    prog[0]  = 32'h2001_FFFF;             // addi $1,$0,-1
    prog[1]  = 32'h2002_0001;             // addi $2,$0,1
    prog[2]  = 32'h0022_182A;             // slt  $3,$1,$2
    prog[3]  = 32'h0041_3822;             // sub  $7,$2,$1
    prog[4]  = 32'h0022_4024;             // and  $8,$1,$2
    prog[5]  = 32'h0022_4825;             // or   $9,$1,$2
    prog[6]  = 32'h2000_0007;             // addi $0,$0,7
    prog[7]  = 32'h0002_5020;             // add  $10,$0,$2
    prog[8]  = 32'hAC09_0080;             // sw   $9,0x80($0)
    prog[9]  = 32'h8C0B_0080;             // lw   $11,0x80($0)
    prog[10] = 32'h0800_000A;             // j    self
    do_reset();
    wait_fetch(32'h20, "alu_prog", cyc);
    check("alu_prog_cycles", 64'(cyc),             64'd32);
    check("slt_signed",      64'(dut.rf_q[3]),     64'h1);
    check("sub_result",      64'(dut.rf_q[7]),     64'h2);
    check("and_result",      64'(dut.rf_q[8]),     64'h1);
    check("or_result",       64'(dut.rf_q[9]),     64'hFFFF_FFFF);
    check("r0_reads_zero",   64'(dut.rf_q[10]),    64'h1);
    wait_fetch(32'h24, "sw_zw", cyc);
    check("sw_zero_wait_cycles", 64'(cyc),    64'd4);
    check("sw_zw_mem",           64'(mem[32]), 64'hFFFF_FFFF);
    wait_fetch(32'h28, "lw_zw", cyc);
    check("lw_zero_wait_cycles", 64'(cyc),            64'd5);
    check("lw_zw_rf11",          64'(dut.rf_q[11]),   64'hFFFF_FFFF);
    check("x64_lw",  dut64.rf_q[1], 64'h0000_0000_FFFF_FFFF);
    check("x64_add", dut64.rf_q[3], 64'h0000_0001_0000_0000);

    // ---- reset during a load wait ----
    clear_prog();
    prog[0]  = 32'h8C01_0080;             // lw $1,0x80($0)
    prog[32] = 32'h1234_5678;
    wait_cfg = 3;
    do_reset();
    cyc = 0;
    while (state_o != 4'd5 && cyc < 100) begin tick(1); cyc++; end
    check("memrd_reached", 64'(state_o), 64'd5);
    tick(1);
    check("memrd_waiting", 64'(mem_req), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_mem_req", 64'(mem_req),  64'd0);
    check("abort_state",   64'(state_o),  64'd0);
    check("abort_pc",      64'(dut.pc_q), 64'h0);
    do_reset();
    check("abort_rf1",      64'(dut.rf_q[1]), 64'h0);
    check("restart_req",    64'(mem_req),     64'd1);
    check("restart_addr",   64'(mem_addr),    64'h0);
    wait_cfg = 0;
    tick(5);
    check("restart_lw_rf1", 64'(dut.rf_q[1]), 64'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address/register width; legal values 32 and 64; instructions are always 32 bits.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have ports:
  clk  input  1  single clock; all state changes on rising edge.
  reset  input  1  asynchronous, active-low reset.
  mem_req  output  1  memory transfer request.
  mem_we  output  1  1 = write, 0 = read; valid while mem_req.
  mem_addr  output  XLEN  byte address; valid while mem_req.
  mem_wdata  output  XLEN  store data; valid while mem_req && mem_we.
  mem_rdata  input  XLEN  read data; sampled on the completing cycle.
  mem_ready  input  1  memory accepts/completes the current transfer.
  err  output  1  sticky illegal-instruction flag.
  state_o  output  4  current FSM state encoding, for debug.

Function
REQ-004 SHALL implement a multicycle MIPS subset over one unified memory: R-type add/sub/and/or/slt (opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
REQ-005 SHALL use FSM states FETCH, DECODE, EXEC_R, WB_R, MEMADR, MEMRD, MEMWB, MEMWR, BEQ, EXEC_I, WB_I, JUMP, ERROR.
REQ-006 SHALL perform a transfer only on a cycle with mem_req && mem_ready; while mem_ready is 0, the FSM stays in its state and mem_addr/mem_we/mem_wdata stay stable.
REQ-007 SHALL assert mem_req only in FETCH, MEMRD and MEMWR; mem_ready on the first cycle (zero-wait) SHALL complete the transfer.
REQ-008 FETCH: mem_addr=PC, read; on completion IR<=mem_rdata[31:0], PC<=PC+4, go to DECODE.
REQ-009 DECODE: latch A=rf[rs], B=rf[rt]; ALUOut<=PC+(sext(imm)<<2); next state by opcode: R->EXEC_R, lw/sw->MEMADR, beq->BEQ, addi->EXEC_I, j->JUMP, any other opcode or R-type funct->ERROR.
REQ-010 EXEC_R->WB_R writes rf[rd]; EXEC_I->WB_I writes rf[rt]=A+sext(imm).
REQ-011 MEMADR: ALUOut<=A+sext(imm) mod 2^XLEN; lw->MEMRD, sw->MEMWR.
REQ-012 MEMRD: on completion latch data; MEMWB writes rf[rt]. MEMWR: mem_we=1, mem_wdata=B; on completion return to FETCH.
REQ-013 BEQ: if A==B then PC<=ALUOut; always return to FETCH.
REQ-014 JUMP: PC<={PC[XLEN-1:28], IR[25:0], 2'b00}; return to FETCH.
REQ-015 All writeback states SHALL return to FETCH; zero-wait cycle counts: beq 3, j 3, R 4, addi 4, sw 4, lw 5.
REQ-016 Immediates SHALL be sign-extended to XLEN; slt SHALL be signed, result 1 or 0 zero-extended; add/sub wrap modulo 2^XLEN.
REQ-017 Register 0 SHALL read as 0; writes to it are discarded.
REQ-018 ERROR SHALL be terminal: err=1, mem_req=0, no register/PC change until reset.

Reset
REQ-019 While reset=0: PC=RESET_PC, state=FETCH, all 32 registers=0, IR=0, err=0, mem_req=0 asynchronously.
REQ-020 mem_req SHALL rise in the first clk cycle after reset deasserts; a transfer in progress at reset assertion is abandoned.

Structure
REQ-021 Package mc_pkg SHALL hold the state enum, opcode/funct constants and the ALU-control enum.
REQ-022 FSM and decode SHALL be one sub-module mc_ctrl; datapath registers, register file and ALU stay in mc_datapath.

Verification
REQ-023 Reset to PC=0, memory: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> rf[3]=2 after 12 cycles zero-wait.
REQ-024 sw $1,8($0) then lw $4,8($0) with mem_ready low 3 cycles per transfer -> addr 8 write data 5 held stable, rf[4]=5.
REQ-025 beq $1,$1,+2 at PC=0x10 -> next fetch address 0x1C; with unequal operands -> 0x14.
REQ-026 j 0x40 at PC=0x100 -> next fetch 0x100; opcode 0x3F -> err=1, mem_req stays 0 for 10 cycles.
REQ-027 slt with $1=-1, $2=1 -> 1; addi $0,$0,7 -> rf[0] reads 0; XLEN=64 add 0xFFFF_FFFF+1 -> 0x1_0000_0000.
REQ-028 reset asserted mid-MEMRD wait -> mem_req drops immediately; after release fetch from RESET_PC.
